// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// blank code, scan-state encoding and the leading-zero mask helper.
package seg_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    BLANK   = 1'b0,
    DISPLAY = 1'b1
  } scan_state_e;

  // Walks from digit n-1 down to digit 1 and marks zeros until the first
  // nonzero digit. Digit 0 is never marked, so a zero word still shows "0".
  function automatic logic [7:0] lz_mask(input logic [31:0] word, input int n);
    logic [7:0] m;
    logic       run;
    m   = '0;
    run = 1'b1;
    for (int d = 7; d >= 1; d--) begin
      if (d < n) begin
        if (run && (word[4*d +: 4] == 4'h0)) m[d] = 1'b1;
        else run = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seven_seg_phase_counter.sv
// Loadable down-counter timing one scan phase; tc flags the last cycle of
// the phase, when the count has run down to the supplied terminal value.
module seven_seg_phase_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic [CW-1:0] term,
  output logic          tc
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (load) count <= load_val;
    else           count <= count - CW'(1);
  end

  assign tc = (count == term);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller: blanks, then lights each digit in turn,
// and double-buffers new display words so they only commit at frame ends.
module seven_seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    lz_suppress,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAXLEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW     = ($clog2(MAXLEN) > 0) ? $clog2(MAXLEN) : 1;

  // Each phase starts at count 0 and counts down through the wrap, so the
  // reset value of the counter is already a valid phase start. The phase
  // ends when it has stepped LEN-1 times, i.e. at 0 - (LEN-1) modulo 2^CW.
  localparam logic [CW-1:0] BLANK_TERM = CW'((1 << CW) - (BLANK_CYCLES - 1));
  localparam logic [CW-1:0] DISP_TERM  = CW'((1 << CW) - (REFRESH_DIV - 1));
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  scan_state_e             state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [NUM_DIGITS-1:0]   dig_en_n;
  logic [3:0]              bcd_n;
  logic [CW-1:0]           term;
  logic                    tc;

  logic [4*NUM_DIGITS-1:0] disp, pend_buf, commit_word;
  logic [NUM_DIGITS-1:0]   mask, mask_commit;
  logic                    pending, xfer, boundary;

  assign term = (state == BLANK) ? BLANK_TERM : DISP_TERM;

  seven_seg_phase_counter #(.CW(CW)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (tc),
    .load_val ({CW{1'b0}}),
    .term     (term),
    .tc       (tc)
  );

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    dig_en_n = dig_en;
    bcd_n    = bcd;
    case (state)
      BLANK: begin
        if (tc) begin
          state_n  = DISPLAY;
          dig_en_n = NUM_DIGITS'(1) << idx;
          bcd_n    = mask[idx] ? BLANK_CODE : disp[4*idx +: 4];
        end
      end
      DISPLAY: begin
        if (tc) begin
          state_n  = BLANK;
          idx_n    = (idx == LAST_IDX) ? '0 : idx + IW'(1);
          dig_en_n = '0;
          bcd_n    = BLANK_CODE;
        end
      end
      default: state_n = BLANK;
    endcase
  end

  // Load port: a word transfers on any rising edge where load_valid and
  // load_ready are both high; load_ready stays low while a word is pending.
  assign load_ready  = !pending;
  assign xfer        = load_valid && load_ready;
  assign boundary    = (state == DISPLAY) && (idx == LAST_IDX) && tc;
  assign frame_done  = boundary;
  assign commit_word = xfer ? load_data : pend_buf;
  assign mask_commit = lz_suppress ? NUM_DIGITS'(lz_mask(32'(commit_word), NUM_DIGITS)) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BLANK;
      idx      <= '0;
      dig_en   <= '0;
      bcd      <= BLANK_CODE;
      disp     <= '0;
      mask     <= '0;
      pend_buf <= '0;
      pending  <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      dig_en <= dig_en_n;
      bcd    <= bcd_n;
      if (boundary) begin
        // A word arriving on the boundary edge bypasses the pending buffer.
        if (xfer || pending) begin
          disp <= commit_word;
          mask <= mask_commit;
        end
        pending <= 1'b0;
      end else if (xfer) begin
        pend_buf <= load_data;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: a cycle-position reference model checks every
// cycle, while vector tables and short sequences pin down load/commit corners.
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int R     = 8;
  localparam int B     = 2;
  localparam int SLOT  = B + R;
  localparam int FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          lz_suppress = 1'b0;
  logic [15:0]   load_data = '0;
  logic          load_ready;
  logic [3:0]    bcd;
  logic [N-1:0]  dig_en;
  logic          frame_done;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .lz_suppress (lz_suppress),
    .bcd         (bcd),
    .dig_en      (dig_en),
    .frame_done  (frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: t counts cycles since reset release (1 = reset cycle).
  int          t;
  logic [15:0] m_disp, m_buf;
  logic [3:0]  m_mask;
  logic        m_pend;

  typedef struct {
    logic [15:0] data;
    logic        lz;
    logic [15:0] shown;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_mask(input logic [15:0] w, input logic lz);
    logic [3:0] m;
    m = '0;
    if (lz) begin
      for (int d = N - 1; d >= 1; d--) begin
        if (w[4*d +: 4] != 4'h0) break;
        m[d] = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic model_reset();
    t      = 1;
    m_disp = '0;
    m_buf  = '0;
    m_mask = '0;
    m_pend = 1'b0;
  endtask

  // Called at a falling edge: check this cycle's outputs, then advance.
  task automatic step();
    int p, d, s;
    logic [3:0] exp_dig, exp_bcd;
    logic xfer;
    p = (t - 1) % FRAME;
    d = p / SLOT;
    s = p % SLOT;
    exp_dig = (s < B) ? 4'd0 : 4'(1 << d);
    exp_bcd = (s < B) ? 4'hF : (m_mask[d] ? 4'hF : m_disp[4*d +: 4]);
    check("dig_en", dig_en, exp_dig);
    check("bcd", bcd, exp_bcd);
    check("frame_done", frame_done, (p == FRAME - 1));
    check("load_ready", load_ready, !m_pend);
    xfer = load_valid && !m_pend;
    if (p == FRAME - 1) begin
      if (xfer) begin
        m_disp = load_data;
        m_mask = ref_mask(load_data, lz_suppress);
      end else if (m_pend) begin
        m_disp = m_buf;
        m_mask = ref_mask(m_buf, lz_suppress);
      end
      m_pend = 1'b0;
    end else if (xfer) begin
      m_buf  = load_data;
      m_pend = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    t++;
  endtask

  task automatic step_to(input int target);
    for (int k = 0; k < FRAME && ((t - 1) % FRAME) != target; k++) step();
  endtask

  // Steps one frame's worth of cycles, recording the code shown mid-slot.
  task automatic capture_frame(output logic [15:0] word);
    int p;
    word = '0;
    for (int k = 0; k < FRAME; k++) begin
      p = (t - 1) % FRAME;
      if ((p % SLOT) == 5) word[4*(p/SLOT) +: 4] = bcd;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          fd_q[$];
    logic [15:0] got;
    int          fd0, fd1;

    vecs[0] = '{16'h1234, 1'b0, 16'h1234};
    vecs[1] = '{16'h0070, 1'b1, 16'hFF70};
    vecs[2] = '{16'h0000, 1'b1, 16'hFFF0};
    vecs[3] = '{16'h0000, 1'b0, 16'h0000};
    vecs[4] = '{16'h1004, 1'b1, 16'h1004};
    vecs[5] = '{16'h00A0, 1'b1, 16'hFFA0};
    vecs[6] = '{16'h0102, 1'b1, 16'hF102};
    vecs[7] = '{16'h0305, 1'b0, 16'h0305};

    // Reset, then idle scanning of the cleared display.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_dig_en", dig_en, 0);
    check("rst_bcd", bcd, 4'hF);
    check("rst_ready", load_ready, 1);
    check("rst_frame_done", frame_done, 0);
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (frame_done) fd_q.push_back(t);
      step();
    end
    check("fd_count", fd_q.size(), 2);
    fd0 = (fd_q.size() > 0) ? fd_q[0] : 0;
    fd1 = (fd_q.size() > 1) ? fd_q[1] : 0;
    check("fd_first", fd0, 40);
    check("fd_second", fd1, 80);

    // Mid-frame loads from the vector table.
    foreach (vecs[i]) begin
      step_to(15);
      load_valid  = 1'b1;
      load_data   = vecs[i].data;
      lz_suppress = vecs[i].lz;
      step();
      load_valid = 1'b0;
      check("ready_drop", load_ready, 0);
      step_to(0);
      check("ready_back", load_ready, 1);
      capture_frame(got);
      check("shown", got, vecs[i].shown);
    end

    // Valid held high: the second word waits for the boundary.
    lz_suppress = 1'b0;
    step_to(5);
    load_valid = 1'b1;
    load_data  = 16'h5555;
    step();
    load_data = 16'h9999;
    step_to(FRAME - 1);
    step();
    step();
    load_valid = 1'b0;
    check("hold_ready", load_ready, 0);
    capture_frame(got);
    check("hold_first", got, 16'h5555);
    capture_frame(got);
    check("hold_second", got, 16'h9999);

    // Load offered on the frame_done cycle commits on that same edge.
    step_to(FRAME - 1);
    check("fd_cycle", frame_done, 1);
    check("fd_ready_pre", load_ready, 1);
    load_valid = 1'b1;
    load_data  = 16'h8642;
    step();
    load_valid = 1'b0;
    check("fd_ready_post", load_ready, 1);
    capture_frame(got);
    check("fd_word", got, 16'h8642);

    // Randomized traffic against the model.
    for (int k = 0; k < 800; k++) begin
      load_valid  = ($urandom_range(0, 3) == 0);
      lz_suppress = $urandom_range(0, 1) == 1;
      for (int d = 0; d < N; d++)
        load_data[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step();
    end
    load_valid = 1'b0;

    // Asynchronous reset while digit 2 is lit.
    step_to(25);
    check("pre_rst_dig_en", dig_en, 4'b0100);
    #1 rst = 1'b1;
    #1;
    check("async_dig_en", dig_en, 0);
    check("async_bcd", bcd, 4'hF);
    check("async_ready", load_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("post_rst_ready", load_ready, 1);
    capture_frame(got);
    check("post_rst_word", got, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
